xge_fifo_pkt_arb: RTL and testbench



---
 rtl/xge_fifo_pkt_arb.sv | 160 ++++++++++++++++
 tb/tb_xge_fifo_pkt_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_fifo_pkt_arb.sv
// Packet-aware round-robin arbiter between two first-word-fall-through FIFOs
// feeding a single MAC TX datapath; switches sources only on packet boundaries.
module xge_fifo_pkt_arb #(
  parameter int DWIDTH     = 66,
  parameter int MAX_WORDS  = 1200,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 11
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [DWIDTH-1:0] s0_rdata,
  input  logic              s0_rempty,
  output logic              s0_ren,
  input  logic [DWIDTH-1:0] s1_rdata,
  input  logic              s1_rempty,
  output logic              s1_ren,
  input  logic              enable,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_sop,
  output logic              err_len
);

  localparam int SOP = DWIDTH - 2;
  localparam int EOP = DWIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_WORDS - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PKT, DROP, GAP} state_t;
  localparam state_t AFTER_EOP = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t                state_reg, state_next;
  logic [1:0]            grant_reg, grant_next;
  logic                  last_reg, last_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [3:0]            gap_reg, gap_next;
  logic [DWIDTH-1:0]     data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  esop_reg, esop_next;
  logic                  elen_reg, elen_next;

  logic              pop_ok, pop, src, done;
  logic [1:0]        ren, empty;
  logic [DWIDTH-1:0] head;

  // Reads are gated by reset so an abandoned packet never loses a word during reset.
  assign empty  = {s1_rempty, s0_rempty};
  assign pop_ok = rrst_n & (((state_reg == PKT) & (~valid_reg | out_ready)) |
                            (state_reg == DROP));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ren
      assign ren[gi] = pop_ok & grant_reg[gi] & ~empty[gi];
    end
  endgenerate

  assign s0_ren = ren[0];
  assign s1_ren = ren[1];
  assign pop    = |ren;
  assign src    = grant_reg[1];
  assign head   = src ? s1_rdata : s0_rdata;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    data_next  = data_reg;
    valid_next = valid_reg & ~out_ready;
    esop_next  = 1'b0;
    elen_next  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && (!s0_rempty || !s1_rempty)) begin
          if (!s0_rempty && !s1_rempty) grant_next = last_reg ? 2'b01 : 2'b10;
          else                          grant_next = s0_rempty ? 2'b10 : 2'b01;
          state_next = PKT;
          cnt_next   = '0;
        end
      end
      PKT: begin
        if (pop) begin
          if (cnt_reg == '0 && !head[SOP]) begin
            // Headless packet: discard everything up to its EOP.
            esop_next = 1'b1;
            if (head[EOP]) done = 1'b1;
            else           state_next = DROP;
          end else begin
            data_next  = head;
            valid_next = 1'b1;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg != '0 && head[SOP]) begin
              data_next[SOP] = 1'b0;
              esop_next      = 1'b1;
            end
            if (head[EOP]) begin
              done = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
              data_next[EOP] = 1'b1;
              elen_next      = 1'b1;
              state_next     = DROP;
            end
          end
        end
      end
      DROP: begin
        if (pop && head[EOP]) done = 1'b1;
      end
      GAP: begin
        grant_next = 2'b00;
        if (gap_reg == GAP_LAST) state_next = IDLE;
        else                     gap_next   = gap_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (done) begin
      last_next  = src;
      grant_next = 2'b00;
      gap_next   = '0;
      state_next = AFTER_EOP;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      esop_reg  <= 1'b0;
      elen_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      esop_reg  <= esop_next;
      elen_reg  <= elen_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);
  assign err_sop   = esop_reg;
  assign err_len   = elen_reg;

endmodule

// File: tb/tb_xge_fifo_pkt_arb.sv
// Directed bench for xge_fifo_pkt_arb: FIFO models feed a default instance and
// a short-MAX_WORDS instance used for truncation.
module tb_xge_fifo_pkt_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rrst_n, enable, out_ready;

  logic [65:0] mem0 [64];
  logic [65:0] mem1 [64];
  logic [65:0] memt [64];
  logic [5:0]  wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0, wpt = '0, rpt = '0;

  logic [65:0] s0_rdata, s1_rdata, t_rdata;
  logic        s0_rempty, s1_rempty, t_rempty;
  logic        s0_ren, s1_ren, t_ren, t_s1_ren;
  logic [65:0] out_data, t_out_data;
  logic        out_valid, t_out_valid;
  logic [1:0]  grant, t_grant;
  logic        busy, t_busy, err_sop, err_len, t_err_sop, t_err_len;

  assign s0_rdata  = mem0[rp0];
  assign s0_rempty = (rp0 == wp0);
  assign s1_rdata  = mem1[rp1];
  assign s1_rempty = (rp1 == wp1);
  assign t_rdata   = memt[rpt];
  assign t_rempty  = (rpt == wpt);

  always @(posedge clk) begin
    if (s0_ren) rp0 <= rp0 + 1'b1;
    if (s1_ren) rp1 <= rp1 + 1'b1;
    if (t_ren)  rpt <= rpt + 1'b1;
  end

  xge_fifo_pkt_arb u_dut (
    .rclk(clk), .rrst_n(rrst_n),
    .s0_rdata(s0_rdata), .s0_rempty(s0_rempty), .s0_ren(s0_ren),
    .s1_rdata(s1_rdata), .s1_rempty(s1_rempty), .s1_ren(s1_ren),
    .enable(enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .busy(busy),
    .err_sop(err_sop), .err_len(err_len)
  );

  xge_fifo_pkt_arb #(.MAX_WORDS(4), .CNT_WIDTH(3)) u_trunc (
    .rclk(clk), .rrst_n(rrst_n),
    .s0_rdata(t_rdata), .s0_rempty(t_rempty), .s0_ren(t_ren),
    .s1_rdata(66'd0), .s1_rempty(1'b1), .s1_ren(t_s1_ren),
    .enable(enable), .out_data(t_out_data), .out_valid(t_out_valid),
    .out_ready(out_ready), .grant(t_grant), .busy(t_busy),
    .err_sop(t_err_sop), .err_len(t_err_len)
  );

  // Monitor: samples on the falling edge, halfway between active edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [65:0] cap[$];
  int          cap_cyc[$];
  logic [65:0] tcap[$];
  int n_ren0 = 0, n_ren1 = 0, n_cross = 0, n_esop = 0, n_elen = 0;
  int nt_ren = 0, nt_esop = 0, nt_elen = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      cap.push_back(out_data);
      cap_cyc.push_back(cyc);
    end
    if (t_out_valid && out_ready) tcap.push_back(t_out_data);
    if (s0_ren) n_ren0++;
    if (s1_ren) n_ren1++;
    if ((s1_ren && grant == 2'b01) || (s0_ren && grant == 2'b10)) n_cross++;
    if (err_sop) n_esop++;
    if (err_len) n_elen++;
    if (t_ren) nt_ren++;
    if (t_err_sop) nt_esop++;
    if (t_err_len) nt_elen++;
  end

  int passed = 0;
  int total  = 0;

  function automatic logic [65:0] wd(input logic sop, input logic eop, input logic [63:0] p);
    return {eop, sop, p};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input logic [65:0] w);
    case (src)
      0:       begin mem0[wp0] = w; wp0 = wp0 + 1'b1; end
      1:       begin mem1[wp1] = w; wp1 = wp1 + 1'b1; end
      default: begin memt[wpt] = w; wpt = wpt + 1'b1; end
    endcase
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    step(2);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 66'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({s0_ren, s1_ren, err_sop, err_len} !== 4'b0) $display("FAIL reset_ren_err: got %b want 0000", {s0_ren, s1_ren, err_sop, err_len}); else passed++;
    rrst_n = 1'b1;
    step(1);
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [7:0] ren_v, ov_v, g_v, b_v;
    logic [65:0] d_v [8];
    push(0, wd(1, 0, 64'h11)); push(0, wd(0, 0, 64'h12)); push(0, wd(0, 1, 64'h13));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ren_v[k] = s0_ren; ov_v[k] = out_valid; g_v[k] = (grant == 2'b01); b_v[k] = busy;
      d_v[k] = out_data;
      @(posedge clk); #1;
    end
    total++; if (ren_v !== 8'b0000_1110) $display("FAIL single_ren: got %b want 00001110", ren_v); else passed++;
    total++; if (ov_v !== 8'b0001_1100) $display("FAIL single_valid: got %b want 00011100", ov_v); else passed++;
    total++; if (g_v !== 8'b0000_1110) $display("FAIL single_grant: got %b want 00001110", g_v); else passed++;
    total++; if (b_v !== 8'b0001_1110) $display("FAIL single_busy: got %b want 00011110", b_v); else passed++;
    total++; if (d_v[2] !== wd(1, 0, 64'h11)) $display("FAIL single_w0: got %h want %h", d_v[2], wd(1, 0, 64'h11)); else passed++;
    total++; if (d_v[3] !== wd(0, 0, 64'h12)) $display("FAIL single_w1: got %h want %h", d_v[3], wd(0, 0, 64'h12)); else passed++;
    total++; if (d_v[4] !== wd(0, 1, 64'h13)) $display("FAIL single_w2: got %h want %h", d_v[4], wd(0, 1, 64'h13)); else passed++;
    step(4);
    $display("test_single: done");
  endtask

  task automatic test_fairness();
    logic [65:0] exp_w [8];
    int cross0;
    rrst_n = 1'b0; step(1); rrst_n = 1'b1;
    cap.delete(); cap_cyc.delete();
    cross0 = n_cross;
    for (int p = 0; p < 4; p++) begin
      exp_w[2*p]   = wd(1, 0, 64'hA0 + 64'(16*p));
      exp_w[2*p+1] = wd(0, 1, 64'hA1 + 64'(16*p));
    end
    push(0, exp_w[0]); push(0, exp_w[1]); push(0, exp_w[4]); push(0, exp_w[5]);
    push(1, exp_w[2]); push(1, exp_w[3]); push(1, exp_w[6]); push(1, exp_w[7]);
    step(40);
    total++; if (cap.size() != 8) $display("FAIL fair_count: got %0d want 8", cap.size()); else passed++;
    if (cap.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (cap[i] !== exp_w[i]) $display("FAIL fair_word%0d: got %h want %h", i, cap[i], exp_w[i]); else passed++;
      end
      for (int p = 1; p < 4; p++) begin
        total++;
        if (cap_cyc[2*p] - cap_cyc[2*p-1] - 1 != 2)
          $display("FAIL fair_gap%0d: got %0d want 2", p, cap_cyc[2*p] - cap_cyc[2*p-1] - 1);
        else passed++;
      end
    end
    total++; if (n_cross - cross0 != 0) $display("FAIL fair_cross_ren: got %0d want 0", n_cross - cross0); else passed++;
    $display("test_fairness: done");
  endtask

  task automatic test_backpressure();
    int ren0_start;
    logic [65:0] hold;
    logic stable_bad, stall_ren;
    cap.delete(); cap_cyc.delete();
    ren0_start = n_ren0;
    stable_bad = 1'b0; stall_ren = 1'b0; hold = '0;
    for (int i = 0; i < 8; i++) push(0, wd(i == 0, i == 7, 64'h30 + 64'(i)));
    for (int i = 0; i < 30 && cap.size() < 3; i++) step(1);
    total++; if (cap.size() < 3) $display("FAIL bp_start_timeout: got %0d words want 3", cap.size()); else passed++;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) hold = out_data;
      else if (out_data !== hold || out_valid !== 1'b1) stable_bad = 1'b1;
      if (s0_ren) stall_ren = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    step(20);
    total++; if (stable_bad !== 1'b0) $display("FAIL bp_stable: got unstable=%b want 0", stable_bad); else passed++;
    total++; if (stall_ren !== 1'b0) $display("FAIL bp_stall_ren: got %b want 0", stall_ren); else passed++;
    total++; if (n_ren0 - ren0_start != 8) $display("FAIL bp_pops: got %0d want 8", n_ren0 - ren0_start); else passed++;
    total++; if (cap.size() != 8) $display("FAIL bp_count: got %0d want 8", cap.size()); else passed++;
    if (cap.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (cap[i] !== wd(i == 0, i == 7, 64'h30 + 64'(i)))
          $display("FAIL bp_word%0d: got %h want %h", i, cap[i], wd(i == 0, i == 7, 64'h30 + 64'(i)));
        else passed++;
      end
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_framing();
    int esop0, elen0, ren00;
    cap.delete(); cap_cyc.delete();
    esop0 = n_esop; elen0 = n_elen; ren00 = n_ren0;
    for (int i = 0; i < 4; i++) push(0, wd(0, i == 3, 64'h40 + 64'(i)));
    push(0, wd(1, 0, 64'h50)); push(0, wd(0, 1, 64'h51));
    step(25);
    total++; if (n_esop - esop0 != 1) $display("FAIL frame_err_sop: got %0d want 1", n_esop - esop0); else passed++;
    total++; if (n_elen - elen0 != 0) $display("FAIL frame_err_len: got %0d want 0", n_elen - elen0); else passed++;
    total++; if (n_ren0 - ren00 != 6) $display("FAIL frame_pops: got %0d want 6", n_ren0 - ren00); else passed++;
    total++; if (cap.size() != 2) $display("FAIL frame_count: got %0d want 2", cap.size()); else passed++;
    if (cap.size() == 2) begin
      total++; if (cap[0] !== wd(1, 0, 64'h50)) $display("FAIL frame_w0: got %h want %h", cap[0], wd(1, 0, 64'h50)); else passed++;
      total++; if (cap[1] !== wd(0, 1, 64'h51)) $display("FAIL frame_w1: got %h want %h", cap[1], wd(0, 1, 64'h51)); else passed++;
    end
    $display("test_framing: done");
  endtask

  task automatic test_truncation();
    int ren_s, elen_s, esop_s;
    logic [65:0] exp_t [4];
    tcap.delete();
    ren_s = nt_ren; elen_s = nt_elen; esop_s = nt_esop;
    exp_t[0] = wd(1, 0, 64'h60); exp_t[1] = wd(0, 0, 64'h61);
    exp_t[2] = wd(0, 0, 64'h62); exp_t[3] = wd(0, 1, 64'h63);
    for (int i = 0; i < 6; i++) push(2, wd(i == 0, i == 5, 64'h60 + 64'(i)));
    step(25);
    total++; if (tcap.size() != 4) $display("FAIL trunc_count: got %0d want 4", tcap.size()); else passed++;
    if (tcap.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (tcap[i] !== exp_t[i]) $display("FAIL trunc_word%0d: got %h want %h", i, tcap[i], exp_t[i]); else passed++;
      end
    end
    total++; if (nt_elen - elen_s != 1) $display("FAIL trunc_err_len: got %0d want 1", nt_elen - elen_s); else passed++;
    total++; if (nt_esop - esop_s != 0) $display("FAIL trunc_err_sop: got %0d want 0", nt_esop - esop_s); else passed++;
    total++; if (nt_ren - ren_s != 6) $display("FAIL trunc_pops: got %0d want 6", nt_ren - ren_s); else passed++;
    $display("test_truncation: done");
  endtask

  task automatic test_enable();
    int ren1_s;
    cap.delete(); cap_cyc.delete();
    ren1_s = n_ren1;
    enable = 1'b0;
    push(1, wd(1, 0, 64'h70)); push(1, wd(0, 1, 64'h71));
    step(5);
    total++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL enable_block: got grant=%b busy=%b want 00/0", grant, busy); else passed++;
    total++; if (n_ren1 - ren1_s != 0) $display("FAIL enable_no_pop: got %0d want 0", n_ren1 - ren1_s); else passed++;
    enable = 1'b1;
    step(15);
    total++; if (cap.size() != 2) $display("FAIL enable_count: got %0d want 2", cap.size()); else passed++;
    if (cap.size() == 2) begin
      total++; if (cap[0] !== wd(1, 0, 64'h70)) $display("FAIL enable_w0: got %h want %h", cap[0], wd(1, 0, 64'h70)); else passed++;
    end
    $display("test_enable: done");
  endtask

  task automatic test_reset_mid();
    int n;
    cap.delete(); cap_cyc.delete();
    for (int i = 0; i < 6; i++) push(1, wd(i == 0, i == 5, 64'h80 + 64'(i)));
    for (int i = 0; i < 30 && cap.size() < 2; i++) step(1);
    total++; if (cap.size() < 2) $display("FAIL rmid_start_timeout: got %0d words want 2", cap.size()); else passed++;
    push(0, wd(1, 0, 64'h90)); push(0, wd(0, 1, 64'h91));
    rrst_n = 1'b0;
    @(negedge clk);
    total++; if ({s0_ren, s1_ren} !== 2'b00) $display("FAIL rmid_ren_in_reset: got %b want 00", {s0_ren, s1_ren}); else passed++;
    @(posedge clk); #1;
    rrst_n = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, grant, busy, err_sop, err_len} !== 6'b0) $display("FAIL rmid_outputs: got %b want 000000", {out_valid, grant, busy, err_sop, err_len}); else passed++;
    total++; if (out_data !== 66'd0) $display("FAIL rmid_out_data: got %h want 0", out_data); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (grant !== 2'b01) $display("FAIL rmid_first_grant: got %b want 01", grant); else passed++;
    step(40);
    n = cap.size();
    total++; if (n < 2) $display("FAIL rmid_count: got %0d want >=2", n); else passed++;
    if (n >= 2) begin
      total++; if (cap[n-2] !== wd(1, 0, 64'h90) || cap[n-1] !== wd(0, 1, 64'h91))
        $display("FAIL rmid_src0_pkt: got %h %h want %h %h", cap[n-2], cap[n-1], wd(1, 0, 64'h90), wd(0, 1, 64'h91));
      else passed++;
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_framing();
    test_truncation();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
